// File: rtl/cpu_mem_pkg.sv
// Shared types for the data-memory port arbiter: FSM states and owner encoding.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam logic OWNER_CPU  = 1'b0;
   localparam logic OWNER_HOST = 1'b1;

endpackage

// File: rtl/rr_lock_arbiter2.sv
// Two-way round-robin grant decision with an optional host burst-hold override.
module rr_lock_arbiter2
   import cpu_mem_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
   input  logic              req_cpu_i,
   input  logic              req_host_i,
   input  logic              lock_i,
   input  logic              last_owner_i,
   input  logic [HOLD_W-1:0] hold_cnt_i,
   output logic              grant_o
);

   logic tie_host;

   // Host keeps a tie only while it already owns, asks for the hold and has budget left.
   assign tie_host = lock_i && (last_owner_i == OWNER_HOST) &&
                     (hold_cnt_i < HOLD_W'(MAX_HOLD));

   always_comb begin
      grant_o = last_owner_i;
      if (req_cpu_i && !req_host_i)
         grant_o = OWNER_CPU;
      else if (req_host_i && !req_cpu_i)
         grant_o = OWNER_HOST;
      else if (req_cpu_i && req_host_i)
         grant_o = tie_host ? OWNER_HOST : ~last_owner_i;
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// CPU/host arbiter onto a single-ported data memory: IDLE -> ACCESS -> RESP.
// Define DMEM_ARB_HOST_LOCK_EN to let a locked host keep up to MAX_HOLD tie grants.
module dmem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_HOLD   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr,
   input  logic                    cpu_we,
   input  logic [DATA_WIDTH/8-1:0] cpu_be,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   output logic                    cpu_done,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   input  logic                    host_req,
   input  logic [ADDR_WIDTH-1:0]   host_addr,
   input  logic                    host_we,
   input  logic [DATA_WIDTH/8-1:0] host_be,
   input  logic [DATA_WIDTH-1:0]   host_wdata,
   input  logic                    host_lock,
   output logic                    host_done,
   output logic [DATA_WIDTH-1:0]   host_rdata,
   output logic                    mem_en,
   output logic [DATA_WIDTH/8-1:0] mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    busy,
   output logic                    owner,
   output logic [15:0]             conflict_cnt
);

   localparam int BE_W   = DATA_WIDTH / 8;
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   arb_state_t              state_q, state_d;
   logic                    owner_q, owner_d;
   logic                    last_q, last_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    we_q, we_d;
   logic [BE_W-1:0]         be_q, be_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   crd_q, crd_d;
   logic [DATA_WIDTH-1:0]   hrd_q, hrd_d;
   logic [15:0]             cnt_q, cnt_d;

   logic                    any_req, both_req, decide, grant;
   logic                    arb_lock;
   logic [HOLD_W-1:0]       arb_hold;
   logic                    rd_resp;

   assign any_req  = cpu_req | host_req;
   assign both_req = cpu_req & host_req;
   assign decide   = ((state_q == IDLE) || (state_q == RESP)) && any_req;
   assign rd_resp  = (state_q == RESP) && !we_q;

   rr_lock_arbiter2 #(
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
   ) u_arb (
      .req_cpu_i    (cpu_req),
      .req_host_i   (host_req),
      .lock_i       (arb_lock),
      .last_owner_i (last_q),
      .hold_cnt_i   (arb_hold),
      .grant_o      (grant)
   );

`ifdef DMEM_ARB_HOST_LOCK_EN
   logic [HOLD_W-1:0] hold_q, hold_d;

   // Counts consecutive locked host grants; saturates so a lone locked host cannot wrap it.
   always_comb begin
      hold_d = hold_q;
      if (!host_lock)
         hold_d = '0;
      else if (decide)
         hold_d = (grant == OWNER_HOST) ?
                  ((hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + 1'b1) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) hold_q <= '0;
      else     hold_q <= hold_d;
   end

   assign arb_lock = host_lock;
   assign arb_hold = hold_q;
`else
   logic unused_host_lock;
   assign unused_host_lock = host_lock;
   assign arb_lock = 1'b0;
   assign arb_hold = '0;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      crd_d   = crd_q;
      hrd_d   = hrd_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = any_req ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase
      if (decide) begin
         owner_d = grant;
         last_d  = grant;
         addr_d  = (grant == OWNER_HOST) ? host_addr  : cpu_addr;
         we_d    = (grant == OWNER_HOST) ? host_we    : cpu_we;
         be_d    = (grant == OWNER_HOST) ? host_be    : cpu_be;
         wdata_d = (grant == OWNER_HOST) ? host_wdata : cpu_wdata;
      end
      if (rd_resp) begin
         if (owner_q == OWNER_HOST) hrd_d = mem_rdata;
         else                       crd_d = mem_rdata;
      end
      if (decide && both_req && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWNER_CPU;
         last_q  <= OWNER_HOST;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         crd_q   <= '0;
         hrd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         crd_q   <= crd_d;
         hrd_q   <= hrd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_en    = (state_q == ACCESS);
   assign mem_we    = (mem_en && we_q) ? be_q : '0;
   assign mem_addr  = mem_en ? addr_q  : '0;
   assign mem_wdata = mem_en ? wdata_q : '0;

   // Read data is forwarded during RESP so it is valid alongside done, then held.
   assign cpu_done   = (state_q == RESP) && (owner_q == OWNER_CPU);
   assign host_done  = (state_q == RESP) && (owner_q == OWNER_HOST);
   assign cpu_rdata  = (rd_resp && owner_q == OWNER_CPU)  ? mem_rdata : crd_q;
   assign host_rdata = (rd_resp && owner_q == OWNER_HOST) ? mem_rdata : hrd_q;

   assign busy         = (state_q == ACCESS) || (state_q == RESP);
   assign owner        = owner_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic against a transaction model.
// Lock expectations follow DMEM_ARB_HOST_LOCK_EN when it is defined for the build.
module tb_dmem_port_arbiter;

   localparam int MAXH = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, host_req, host_we, host_lock;
   logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
   logic [3:0]  cpu_be, host_be;
   logic        cpu_done, host_done, mem_en, busy, owner;
   logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_we;
   logic [15:0] conflict_cnt;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(MAXH)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_be(cpu_be),
      .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_addr(host_addr), .host_we(host_we), .host_be(host_be),
      .host_wdata(host_wdata), .host_lock(host_lock), .host_done(host_done),
      .host_rdata(host_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner), .conflict_cnt(conflict_cnt)
   );

   function automatic logic [31:0] init_word(int i);
      return (i == 16) ? 32'hCAFEF00D : 32'h9E3779B9 * (i + 1);
   endfunction

   // Memory environment: 256 words, read data one cycle after mem_en.
   logic [31:0] tmem [256];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) tmem[i] <= init_word(i);
      end else if (mem_en) begin
         mem_rdata <= tmem[mem_addr[9:2]];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) tmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Transaction-level reference: each grant at edge S yields ACCESS in cycle S,
   // RESP in cycle S+1, and the next decision at edge S+2.
   logic [31:0] rmem [256];
   bit          m_ok = 0;
   int          cyc = 0, dec_at = 1 << 30, t_start = 0;
   bit          m_last, m_owner, t_valid, t_own, t_we;
   int          m_hold, m_conf;
   logic [31:0] m_crd, m_hrd, t_addr, t_wdata, t_rd;
   logic [3:0]  t_be;
   int          gq[$], dq[$];

   function automatic bit m_grant(bit c, bit h, bit lk);
      if (c && !h) return 1'b0;
      if (h && !c) return 1'b1;
`ifdef DMEM_ARB_HOST_LOCK_EN
      if (lk && m_last && m_hold < MAXH) return 1'b1;
`endif
      return !m_last;
   endfunction

   task automatic model_step();
      bit g;
      if (t_valid && cyc == t_start) begin
         t_rd = rmem[t_addr[9:2]];
         if (t_we)
            for (int b = 0; b < 4; b++)
               if (t_be[b]) rmem[t_addr[9:2]][8*b +: 8] = t_wdata[8*b +: 8];
      end
      if (t_valid && cyc == t_start + 1 && !rst) begin
         if (!t_we) begin
            if (t_own) m_hrd = t_rd;
            else       m_crd = t_rd;
         end
         t_valid = 0;
      end
      cyc++;
      if (rst) begin
         m_ok = 1; t_valid = 0; m_last = 1; m_owner = 0; m_hold = 0; m_conf = 0;
         m_crd = 0; m_hrd = 0; dec_at = cyc + 1;
         for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
      end else begin
         if (!host_lock) m_hold = 0;
         if (cyc == dec_at) begin
            if (cpu_req || host_req) begin
               g = m_grant(cpu_req, host_req, host_lock);
               if (cpu_req && host_req && m_conf < 65535) m_conf++;
               if (host_lock) m_hold = g ? ((m_hold < MAXH) ? m_hold + 1 : m_hold) : 0;
               m_last = g; m_owner = g; t_own = g; t_valid = 1; t_start = cyc;
               t_addr  = g ? host_addr  : cpu_addr;
               t_we    = g ? host_we    : cpu_we;
               t_be    = g ? host_be    : cpu_be;
               t_wdata = g ? host_wdata : cpu_wdata;
               dec_at = cyc + 2;
            end else begin
               dec_at = cyc + 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      bit acc, rsp;
      logic [31:0] ecr, ehr;
      acc = t_valid && cyc == t_start;
      rsp = t_valid && cyc == t_start + 1;
      ecr = (rsp && !t_own && !t_we) ? t_rd : m_crd;
      ehr = (rsp &&  t_own && !t_we) ? t_rd : m_hrd;
      chk("mem_en",    mem_en,    acc);
      chk("mem_we",    mem_we,    (acc && t_we) ? t_be : 4'h0);
      chk("mem_addr",  mem_addr,  acc ? t_addr : 32'h0);
      chk("mem_wdata", mem_wdata, acc ? t_wdata : 32'h0);
      chk("cpu_done",  cpu_done,  rsp && !t_own);
      chk("host_done", host_done, rsp && t_own);
      chk("cpu_rdata", cpu_rdata, ecr);
      chk("host_rdata", host_rdata, ehr);
      chk("busy",      busy,      acc || rsp);
      chk("owner",     owner,     m_owner);
      chk("conflict",  conflict_cnt, m_conf);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_ok) compare_all();
      if (cpu_done)  begin gq.push_back(0); dq.push_back(cyc); end
      if (host_done) begin gq.push_back(1); dq.push_back(cyc); end
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_be = 4'hF; cpu_addr = 0; cpu_wdata = 0;
      host_req = 0; host_we = 0; host_be = 4'hF; host_addr = 0; host_wdata = 0;
      host_lock = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; tick(); tick();
      rst = 0;
      gq.delete(); dq.delete();
   endtask

   task automatic run_until(input int n, input int budget);
      int k = 0;
      while (gq.size() < n && k < budget) begin tick(); k++; end
      chk("done_budget", gq.size() >= n, 1'b1);
      cpu_req = 0; host_req = 0;
   endtask

   initial begin
      int exp_lock [5];
      idle_inputs();
      rst = 1;
      do_reset();
      chk("rst_busy", busy, 1'b0);
      chk("rst_owner", owner, 1'b0);
      chk("rst_conf", conflict_cnt, 16'h0);
      chk("rst_mem_en", mem_en, 1'b0);

      // Solo CPU read of 0x40.
      cpu_req = 1; cpu_addr = 32'h40; cpu_we = 0;
      tick();
      chk("rd_mem_en", mem_en, 1'b1);
      chk("rd_addr", mem_addr, 32'h40);
      chk("rd_no_done", cpu_done, 1'b0);
      tick();
      chk("rd_done", cpu_done, 1'b1);
      chk("rd_data", cpu_rdata, 32'hCAFEF00D);
      chk("rd_hdone", host_done, 1'b0);
      cpu_req = 0;
      tick();
      chk("rd_idle", busy, 1'b0);
      chk("rd_hold", cpu_rdata, 32'hCAFEF00D);

      // Host partial write.
      host_req = 1; host_we = 1; host_be = 4'b0011;
      host_wdata = 32'h12345678; host_addr = 32'h100;
      tick();
      chk("wr_we", mem_we, 4'b0011);
      chk("wr_wdata", mem_wdata, 32'h12345678);
      chk("wr_addr", mem_addr, 32'h100);
      tick();
      chk("wr_done", host_done, 1'b1);
      chk("wr_rdata", host_rdata, 32'h0);
      host_req = 0;
      tick();
      chk("wr_we_off", mem_we, 4'b0000);

      // Contention from reset: CPU wins the first tie.
      do_reset();
      cpu_req = 1; host_req = 1; cpu_addr = 32'h8; host_addr = 32'hC;
      run_until(4, 40);
      if (gq.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk("rr_order", gq[i], i % 2);
         for (int i = 0; i < 3; i++) chk("rr_spacing", dq[i+1] - dq[i], 2);
      end
      tick();
      chk("rr_conf", conflict_cnt, 16'd4);

      // Reset during ACCESS drops the transfer.
      do_reset();
      cpu_req = 1; cpu_addr = 32'h40;
      tick();
      chk("rm_access", mem_en, 1'b1);
      rst = 1; cpu_req = 0;
      tick();
      chk("rm_done", cpu_done, 1'b0);
      chk("rm_mem_en", mem_en, 1'b0);
      chk("rm_busy", busy, 1'b0);
      chk("rm_rdata", cpu_rdata, 32'h0);
      rst = 0;
      tick();
      chk("rm_done2", cpu_done, 1'b0);

      // Host burst with lock held while both request.
      do_reset();
      host_lock = 1; host_req = 1;
      tick();
      cpu_req = 1;
      run_until(5, 60);
`ifdef DMEM_ARB_HOST_LOCK_EN
      exp_lock = '{1, 1, 1, 0, 1};
`else
      exp_lock = '{1, 0, 1, 0, 1};
`endif
      if (gq.size() >= 5)
         for (int i = 0; i < 5; i++) chk("lock_order", gq[i], exp_lock[i]);
      host_lock = 0;
      tick();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(0, 149) == 0);
         cpu_req    = ($urandom_range(0, 2) != 0);
         host_req   = ($urandom_range(0, 2) != 0);
         host_lock  = ($urandom_range(0, 3) != 0);
         cpu_we     = $urandom_range(0, 1);
         host_we    = $urandom_range(0, 1);
         cpu_be     = 4'($urandom);
         host_be    = 4'($urandom);
         cpu_addr   = $urandom;
         host_addr  = $urandom;
         cpu_wdata  = $urandom;
         host_wdata = $urandom;
         tick();
      end
      rst = 0;
      idle_inputs();
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; byte enables are DATA_WIDTH/8 bits wide.
REQ-003 SHALL have parameter MAX_HOLD, default 16, maximum consecutive locked host grants.
REQ-004 SHALL have one clock and a synchronous, active-high reset: `clk  in  1  rising-edge clock`; `rst  in  1  synchronous active-high reset`.
REQ-005 SHALL have the CPU requester ports:
- `cpu_req  in  1  level request`
- `cpu_addr  in  ADDR_WIDTH`
- `cpu_we  in  1  write`
- `cpu_be  in  DATA_WIDTH/8  byte enables`
- `cpu_wdata  in  DATA_WIDTH`
- `cpu_done  out  1  completion pulse`
- `cpu_rdata  out  DATA_WIDTH`
REQ-006 SHALL have host requester ports `host_req`, `host_addr`, `host_we`, `host_be`, `host_wdata`, `host_done` and `host_rdata`, with the same widths and meanings as the CPU ports, plus `host_lock  in  1  burst hold request`.
REQ-007 SHALL have the memory ports:
- `mem_en  out  1`
- `mem_we  out  DATA_WIDTH/8  byte write strobes`
- `mem_addr  out  ADDR_WIDTH`
- `mem_wdata  out  DATA_WIDTH`
- `mem_rdata  in  DATA_WIDTH  valid 1 cycle after mem_en`
REQ-008 SHALL have the status ports:
- `busy  out  1`
- `owner  out  1  0=CPU, 1=host`
- `conflict_cnt  out  16  count of cycles in which both requesters were pending`

Function
REQ-009 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-010 IDLE SHALL move to ACCESS when either req is high and stay in IDLE otherwise; the grant decision and the granted requester's addr/we/be/wdata SHALL be latched on that edge.
REQ-011 ACCESS SHALL last exactly one cycle and drive mem_en=1, mem_addr/mem_wdata from the latched values, and mem_we = latched be if we=1, else 0.
REQ-012 RESP SHALL last one cycle, pulse the owner's done for one cycle, and place mem_rdata on the owner's rdata for reads.
REQ-013 On a write, rdata SHALL hold its previous value.
REQ-014 The non-owner's done SHALL be 0 in every cycle.
REQ-015 From RESP, the FSM SHALL go directly to ACCESS if any req is high (back-to-back operation, one transfer per 2 cycles) and to IDLE otherwise.
REQ-016 Latency SHALL be fixed: a req sampled in IDLE at edge N yields mem_en at cycle N+1 and done at cycle N+2.
REQ-017 Arbitration SHALL be round-robin: a single requester always wins; on a simultaneous request, the requester not granted last wins.
REQ-018 The round-robin pointer SHALL reset to "last=host", so the CPU wins the first tie.
REQ-019 A requester SHALL hold req and its fields stable until done.
REQ-020 A req dropped during ACCESS/RESP SHALL NOT abort the transfer; done still pulses.
REQ-021 conflict_cnt SHALL increment in each cycle where cpu_req and host_req are both high and the arbiter is deciding (IDLE, or RESP with a next grant), and SHALL saturate at 16'hFFFF.
REQ-022 busy SHALL be 1 in ACCESS and RESP; owner SHALL reflect the latched grant and hold its value in IDLE.

Reset
REQ-023 On rst=1 the FSM SHALL enter IDLE on the next edge; any in-flight transfer is dropped and no done is issued for it.
REQ-024 On rst=1, the following SHALL all be 0: mem_en, mem_we, mem_addr, mem_wdata, cpu_done, host_done, cpu_rdata, host_rdata, busy, owner, conflict_cnt.
REQ-025 On rst=1, the hold counter SHALL be 0 and the round-robin pointer SHALL be set to host.

Configuration
REQ-026 Macro DMEM_ARB_HOST_LOCK_EN defined: while host is owner with host_req=1 and host_lock=1, host SHALL win ties for up to MAX_HOLD consecutive grants.
REQ-027 With DMEM_ARB_HOST_LOCK_EN defined, when the hold count is reached, a pending CPU SHALL receive the next grant, after which the hold counter clears.
REQ-028 With DMEM_ARB_HOST_LOCK_EN defined, the hold counter SHALL clear whenever the CPU is granted or host_lock=0.
REQ-029 Macro undefined: host_lock SHALL be ignored, no hold counter SHALL exist, and arbitration SHALL be pure round-robin.

Structure
REQ-030 The FSM state enum (arb_state_t) and the owner encoding constants OWNER_CPU/OWNER_HOST SHALL reside in shared package cpu_mem_pkg.
REQ-031 The round-robin/lock decision SHALL be a single sub-module, rr_lock_arbiter2: inputs are 2 reqs, lock, last-owner and hold count; output is the grant.

Verification
REQ-032 Verify solo CPU read: cpu_req=1, addr=0x40, mem returns 0xCAFEF00D -> mem_en at N+1, cpu_done at N+2, cpu_rdata=0xCAFEF00D, host_done=0.
REQ-033 Verify host write: host_we=1, be=4'b0011, wdata=0x12345678, addr=0x100 -> mem_we=4'b0011, mem_wdata=0x12345678 for one cycle, host_rdata unchanged.
REQ-034 Verify contention: both reqs held for 4 transfers after reset -> grant order CPU, host, CPU, host; done pulses every 2 cycles; conflict_cnt=4.
REQ-035 Verify reset mid-op: rst asserted in ACCESS of a CPU read -> no cpu_done, all outputs 0 next cycle, IDLE.
REQ-036 Verify lock with DMEM_ARB_HOST_LOCK_EN and MAX_HOLD=3: host owns with host_lock=1 and both reqs held -> grants host, host, host, CPU, host.
REQ-037 Verify lock without DMEM_ARB_HOST_LOCK_EN: same stimulus as REQ-036 -> grants alternate.
